// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   D-stage hazard unit. Every in-flight GPR write is tracked as a
//   {valid, dst, tnew} entry that shifts one slot per clock through
//   NUM_STAGES slots (slot 1 = E, slot NUM_STAGES = oldest). The decoded
//   instruction's sources and their Tuse are compared against the entries
//   to produce the stall, per-operand forwarding selects and a saturating
//   count of stalled cycles.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high; clears entries and counter
//   d_valid     D holds a real instruction
//   d_regwrite  D instruction writes a GPR
//   d_dst       D destination register
//   d_tnew      D Tnew (decoder TnewD)
//   d_src       source registers, operand i at [5i+4:5i]
//   d_tuse      Tuse per operand, all-ones = operand unused
//   flush       kill the instruction leaving D this cycle
//   stall       freeze PC and F/D, bubble into E
//   fwd_sel     per operand: 0 = register file, k = forward from slot k
//   stall_cnt   saturating count of stalled cycles
module hazard_scoreboard #(
    parameter int NUM_STAGES = 3,
    parameter int NUM_SRC    = 2,
    parameter int TW         = 2,
    parameter int SELW       = 3,
    parameter int CNTW       = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     d_valid,
    input  logic                     d_regwrite,
    input  logic [4:0]               d_dst,
    input  logic [TW-1:0]            d_tnew,
    input  logic [NUM_SRC*5-1:0]     d_src,
    input  logic [NUM_SRC*TW-1:0]    d_tuse,
    input  logic                     flush,
    output logic                     stall,
    output logic [NUM_SRC*SELW-1:0]  fwd_sel,
    output logic [CNTW-1:0]          stall_cnt
);

    function automatic logic [TW-1:0] satdec(input logic [TW-1:0] t);
        return (t == '0) ? t : t - 1'b1;
    endfunction

    function automatic logic [CNTW-1:0] satinc(input logic [CNTW-1:0] c);
        return (c == {CNTW{1'b1}}) ? c : c + 1'b1;
    endfunction

    logic                ent_vld  [NUM_STAGES:1];
    logic [4:0]          ent_dst  [NUM_STAGES:1];
    logic [TW-1:0]       ent_tnew [NUM_STAGES:1];
    logic [CNTW-1:0]     cnt_q;

    logic [NUM_SRC-1:0]      found;
    logic [NUM_SRC-1:0]      hazard;
    logic [NUM_SRC*SELW-1:0] fwd;
    logic                    load_e;

    // D stage: compare each operand against the youngest matching entry only;
    // an older, ready producer of the same register holds a stale value.
    always_comb begin
        found  = '0;
        hazard = '0;
        fwd    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = 1; k <= NUM_STAGES; k++) begin
                if (!found[i] && ent_vld[k] &&
                    ent_dst[k] == d_src[5*i +: 5] && d_src[5*i +: 5] != 5'd0) begin
                    found[i] = 1'b1;
                    if (d_tuse[TW*i +: TW] != {TW{1'b1}} &&
                        ent_tnew[k] > d_tuse[TW*i +: TW])
                        hazard[i] = 1'b1;
                    if (ent_tnew[k] == '0)
                        fwd[SELW*i +: SELW] = SELW'(k);
                end
            end
        end
    end

    assign stall     = d_valid && (|hazard);
    assign fwd_sel   = d_valid ? fwd : '0;
    assign stall_cnt = cnt_q;

    // A stalled or flushed instruction never reaches E, so it must not be tracked.
    assign load_e = d_valid && d_regwrite && (d_dst != 5'd0) && !stall && !flush;

    // D -> E boundary and E..oldest shift: entries advance every edge,
    // independent of stall, so a waiting instruction sees aged producers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k <= NUM_STAGES; k++) begin
                ent_vld[k]  <= 1'b0;
                ent_dst[k]  <= 5'd0;
                ent_tnew[k] <= '0;
            end
            cnt_q <= '0;
        end else begin
            ent_vld[1]  <= load_e;
            ent_dst[1]  <= load_e ? d_dst : 5'd0;
            ent_tnew[1] <= load_e ? satdec(d_tnew) : '0;
            for (int k = 2; k <= NUM_STAGES; k++) begin
                ent_vld[k]  <= ent_vld[k-1];
                ent_dst[k]  <= ent_dst[k-1];
                ent_tnew[k] <= satdec(ent_tnew[k-1]);
            end
            if (stall)
                cnt_q <= satinc(cnt_q);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        d_valid;
    logic        d_regwrite;
    logic [4:0]  d_dst;
    logic [1:0]  d_tnew;
    logic [9:0]  d_src;
    logic [3:0]  d_tuse;
    logic        flush;
    logic        stall;
    logic [5:0]  fwd_sel;
    logic [3:0]  stall_cnt;

    int total = 0;
    int bad   = 0;

    hazard_scoreboard #(
        .NUM_STAGES(3), .NUM_SRC(2), .TW(2), .SELW(3), .CNTW(4)
    ) dut (
        .clk(clk), .reset(reset), .d_valid(d_valid), .d_regwrite(d_regwrite),
        .d_dst(d_dst), .d_tnew(d_tnew), .d_src(d_src), .d_tuse(d_tuse),
        .flush(flush), .stall(stall), .fwd_sel(fwd_sel), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive one D-stage instruction: src1/tuse1 are operand 1 (rt), src0/tuse0 operand 0 (rs).
    task automatic drv(input logic v, input logic rw, input logic [4:0] dst,
                       input logic [1:0] tn, input logic [4:0] s0, input logic [1:0] u0,
                       input logic [4:0] s1, input logic [1:0] u1, input logic f);
        d_valid    = v;
        d_regwrite = rw;
        d_dst      = dst;
        d_tnew     = tn;
        d_src      = {s1, s0};
        d_tuse     = {u1, u0};
        flush      = f;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 5'd0, 2'd0, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0);
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++;
        if (stall !== 1'b0 || stall_cnt !== 4'd0) begin
            bad++;
            $display("FAIL reset_state: stall=%b cnt=%0d want stall=0 cnt=0", stall, stall_cnt);
        end
        // Three writers of $8: E/M/W end up with tnew 2,1,0.
        cyc(); drv(1'b1, 1'b1, 5'd8, 2'd3, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0);
        cyc(); cyc(); cyc();
        drv(1'b1, 1'b0, 5'd0, 2'd0, 5'd8, 2'd0, 5'd0, 2'd3, 1'b0);
        @(negedge clk);
        total++;
        if (stall !== 1'b1 || fwd_sel !== 6'd0) begin
            bad++;
            $display("FAIL reset_prefill: stall=%b fwd=%0d want stall=1 fwd=0", stall, fwd_sel);
        end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (stall !== 1'b0 || fwd_sel !== 6'd0 || stall_cnt !== 4'd0) begin
            bad++;
            $display("FAIL reset_mid: stall=%b fwd=%0d cnt=%0d want 0 0 0", stall, fwd_sel, stall_cnt);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drv(1'b1, 1'b1, 5'd9, 2'd3, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0);
        cyc();
        drv(1'b1, 1'b1, 5'd10, 2'd2, 5'd9, 2'd1, 5'd0, 2'd1, 1'b0);
        @(negedge clk);
        total++;
        if (stall !== 1'b1 || fwd_sel !== 6'd0) begin
            bad++;
            $display("FAIL load_use_c0: stall=%b fwd=%0d want stall=1 fwd=0", stall, fwd_sel);
        end
        cyc();
        @(negedge clk);
        total++;
        if (stall !== 1'b0 || fwd_sel !== 6'd0 || stall_cnt !== 4'd1) begin
            bad++;
            $display("FAIL load_use_c1: stall=%b fwd=%0d cnt=%0d want 0 0 1", stall, fwd_sel, stall_cnt);
        end
    endtask

    task automatic test_load_branch();
        do_reset();
        drv(1'b1, 1'b1, 5'd9, 2'd3, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0);
        cyc();
        drv(1'b1, 1'b0, 5'd0, 2'd0, 5'd9, 2'd0, 5'd0, 2'd0, 1'b0);
        @(negedge clk);
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("FAIL load_branch_c0: stall=%b want 1", stall);
        end
        cyc();
        @(negedge clk);
        total++;
        if (stall !== 1'b1 || stall_cnt !== 4'd1) begin
            bad++;
            $display("FAIL load_branch_c1: stall=%b cnt=%0d want 1 1", stall, stall_cnt);
        end
        cyc();
        // The load has aged to the oldest slot with tnew 0.
        @(negedge clk);
        total++;
        if (stall !== 1'b0 || fwd_sel !== 6'd3 || stall_cnt !== 4'd2) begin
            bad++;
            $display("FAIL load_branch_c2: stall=%b fwd=%0d cnt=%0d want 0 3 2", stall, fwd_sel, stall_cnt);
        end
        d_valid = 1'b0;
        #1;
        total++;
        if (stall !== 1'b0 || fwd_sel !== 6'd0) begin
            bad++;
            $display("FAIL load_branch_bubble: stall=%b fwd=%0d want 0 0", stall, fwd_sel);
        end
    endtask

    task automatic test_alu_forward();
        do_reset();
        drv(1'b1, 1'b1, 5'd10, 2'd2, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0);
        cyc();
        drv(1'b1, 1'b0, 5'd0, 2'd0, 5'd0, 2'd3, 5'd10, 2'd1, 1'b0);
        @(negedge clk);
        total++;
        if (stall !== 1'b0 || fwd_sel !== 6'd0) begin
            bad++;
            $display("FAIL alu_adjacent: stall=%b fwd=%0d want 0 0", stall, fwd_sel);
        end
        do_reset();
        drv(1'b1, 1'b1, 5'd10, 2'd2, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0);
        cyc();
        idle();
        cyc();
        drv(1'b1, 1'b0, 5'd0, 2'd0, 5'd0, 2'd3, 5'd10, 2'd0, 1'b0);
        @(negedge clk);
        total++;
        if (stall !== 1'b0 || fwd_sel !== {3'd2, 3'd0}) begin
            bad++;
            $display("FAIL alu_gap: stall=%b fwd=%0d want 0 16", stall, fwd_sel);
        end
    endtask

    task automatic test_tnew_floor();
        do_reset();
        drv(1'b1, 1'b1, 5'd14, 2'd0, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0);
        cyc();
        drv(1'b1, 1'b0, 5'd0, 2'd0, 5'd14, 2'd0, 5'd0, 2'd3, 1'b0);
        @(negedge clk);
        total++;
        if (stall !== 1'b0 || fwd_sel !== 6'd1) begin
            bad++;
            $display("FAIL floor_e: stall=%b fwd=%0d want 0 1", stall, fwd_sel);
        end
        cyc();
        @(negedge clk);
        total++;
        if (stall !== 1'b0 || fwd_sel !== 6'd2) begin
            bad++;
            $display("FAIL floor_m: stall=%b fwd=%0d want 0 2", stall, fwd_sel);
        end
        cyc();
        @(negedge clk);
        total++;
        if (stall !== 1'b0 || fwd_sel !== 6'd3) begin
            bad++;
            $display("FAIL floor_w: stall=%b fwd=%0d want 0 3", stall, fwd_sel);
        end
    endtask

    task automatic test_younger_wins();
        do_reset();
        drv(1'b1, 1'b1, 5'd11, 2'd1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0);
        cyc();
        drv(1'b1, 1'b1, 5'd11, 2'd2, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0);
        cyc();
        // E: $11 tnew 1, M: $11 tnew 0.
        drv(1'b1, 1'b0, 5'd0, 2'd0, 5'd0, 2'd3, 5'd11, 2'd0, 1'b0);
        @(negedge clk);
        total++;
        if (stall !== 1'b1 || fwd_sel !== 6'd0) begin
            bad++;
            $display("FAIL younger_wins: stall=%b fwd=%0d want 1 0", stall, fwd_sel);
        end
        do_reset();
        drv(1'b1, 1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0);
        cyc();
        drv(1'b1, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0);
        @(negedge clk);
        total++;
        if (stall !== 1'b0 || fwd_sel !== 6'd0) begin
            bad++;
            $display("FAIL src_zero: stall=%b fwd=%0d want 0 0", stall, fwd_sel);
        end
    endtask

    task automatic test_flush();
        do_reset();
        drv(1'b1, 1'b1, 5'd12, 2'd3, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1);
        cyc();
        drv(1'b1, 1'b0, 5'd0, 2'd0, 5'd12, 2'd0, 5'd0, 2'd3, 1'b0);
        @(negedge clk);
        total++;
        if (stall !== 1'b0 || fwd_sel !== 6'd0) begin
            bad++;
            $display("FAIL flush_write: stall=%b fwd=%0d want 0 0", stall, fwd_sel);
        end
        do_reset();
        drv(1'b1, 1'b1, 5'd9, 2'd3, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0);
        cyc();
        drv(1'b1, 1'b1, 5'd13, 2'd1, 5'd9, 2'd0, 5'd0, 2'd3, 1'b1);
        @(negedge clk);
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("FAIL flush_stall_c0: stall=%b want 1", stall);
        end
        cyc();
        drv(1'b1, 1'b0, 5'd0, 2'd0, 5'd0, 2'd3, 5'd13, 2'd0, 1'b0);
        @(negedge clk);
        total++;
        if (stall !== 1'b0 || fwd_sel !== 6'd0 || stall_cnt !== 4'd1) begin
            bad++;
            $display("FAIL flush_stall_c1: stall=%b fwd=%0d cnt=%0d want 0 0 1", stall, fwd_sel, stall_cnt);
        end
    endtask

    // Writer of $9 that also reads $9 with Tuse 0: stalls 2 of every 3 cycles.
    task automatic test_saturation();
        do_reset();
        drv(1'b1, 1'b1, 5'd9, 2'd3, 5'd9, 2'd0, 5'd0, 2'd3, 1'b0);
        for (int c = 1; c <= 31; c++) begin
            @(negedge clk);
            if (c == 7) begin
                total++;
                if (stall !== 1'b0 || fwd_sel !== 6'd3 || stall_cnt !== 4'd4) begin
                    bad++;
                    $display("FAIL sat_c7: stall=%b fwd=%0d cnt=%0d want 0 3 4", stall, fwd_sel, stall_cnt);
                end
            end
            if (c == 17) begin
                total++;
                if (stall_cnt !== 4'd10) begin
                    bad++;
                    $display("FAIL sat_c17: cnt=%0d want 10", stall_cnt);
                end
            end
            if (c == 25 || c == 31) begin
                total++;
                if (stall_cnt !== 4'd15) begin
                    bad++;
                    $display("FAIL sat_hold c=%0d: cnt=%0d want 15", c, stall_cnt);
                end
            end
            cyc();
        end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        #1;
        test_reset();
        test_load_use();
        test_load_branch();
        test_alu_forward();
        test_tnew_floor();
        test_younger_wins();
        test_flush();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
